// File: rtl/data_ram_be_pkg.sv
// Shared types for the byte-enabled data RAM: access-size encodings,
// controller states and the load sign/zero-extension helper.
package data_ram_be_pkg;

  // Access size as presented on req_size.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  // INIT runs the zero-fill sweep, RUN serves requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Extend a right-aligned load value to 32 bits. The upper bits of
  // 'shifted' are ignored for byte and half accesses.
  function automatic logic [31:0] load_extend(logic [31:0] shifted, size_e sz, logic uns);
    logic [31:0] v;
    v = '0;
    case (sz)
      SZ_B:    v = uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_H:    v = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      SZ_W:    v = shifted;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/data_ram_be_if.sv
// Request/response bus of the data RAM. The master drives requests and
// observes responses and the fill-in-progress flag.
interface data_ram_be_if #(
  parameter int ADDR_W = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/data_ram_be_dmem_align.sv
// Combinational alignment helper: store lane enables and replicated store
// data, the misalign/illegal-size flag, and load extraction/extension from
// the word read out of the array.
module dmem_align
  import data_ram_be_pkg::*;
(
  // store / request side
  input  size_e       req_size,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data,
  output logic        acc_err,
  // load / response side
  input  logic [31:0] rd_word,
  input  logic [1:0]  rd_lo,
  input  size_e       rd_size,
  input  logic        rd_unsigned,
  output logic [31:0] rd_data
);

  // Lane selection, data replication and the error flag for the request.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    wr_be   = '0;
    wr_data = req_wdata;
    acc_err = 1'b0;
    case (req_size)
      SZ_B: begin
        wr_be   = 4'b0001 << req_lo;
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        wr_be   = req_lo[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
        acc_err = req_lo[0];
      end
      SZ_W: begin
        wr_be   = 4'b1111;
        acc_err = |req_lo;
      end
      default: acc_err = 1'b1;
    endcase
    // An erroneous access must never touch the array.
    if (acc_err) wr_be = '0;
  end

  // Shift the read word down to the addressed byte, then extend.
  always_comb begin
    logic [31:0] shifted;
    shifted = rd_word >> {rd_lo, 3'b000};
    rd_data = load_extend(shifted, rd_size, rd_unsigned);
  end

endmodule

// File: rtl/data_ram_be.sv
// Word-organised data RAM with byte/half/word access, an optional zero-fill
// sweep after reset, and a single-cycle registered response.
module data_ram_be
  import data_ram_be_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  data_ram_be_if.slave bus
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int PTR_W = ADDR_W - 2;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sweep_we;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_q;

  logic             accept;
  logic             st_we;
  logic             ld_en;
  logic [PTR_W-1:0] word_idx;
  size_e            req_size;

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        acc_err;
  logic [31:0] rd_data;

  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        rsp_load_q;
  logic [1:0]  rsp_lo_q;
  size_e       rsp_size_q;
  logic        rsp_uns_q;

  assign req_size = size_e'(bus.req_size);
  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign accept   = bus.req_valid && (state_q == RUN);
  assign st_we    = accept && bus.req_we && !acc_err;
  assign ld_en    = accept && !bus.req_we && !acc_err;

  dmem_align u_align (
    .req_size    (req_size),
    .req_lo      (bus.req_addr[1:0]),
    .req_wdata   (bus.req_wdata),
    .wr_be       (wr_be),
    .wr_data     (wr_data),
    .acc_err     (acc_err),
    .rd_word     (rd_word_q),
    .rd_lo       (rsp_lo_q),
    .rd_size     (rsp_size_q),
    .rd_unsigned (rsp_uns_q),
    .rd_data     (rd_data)
  );

  // Controller state and sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: sweep one word per cycle, leave INIT after the last.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        if (CLEAR_ON_RESET) begin
          sweep_we = 1'b1;
          ptr_d    = ptr_q + PTR_W'(1);
          if (ptr_q == LAST) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Array write port (sweep or lane-masked store) and synchronous read.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps onto RAM macros;
    // clearing is done by the INIT sweep instead.
    if (sweep_we) begin
      mem[ptr_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (ld_en) rd_word_q <= mem[word_idx];
  end

  // Response registers: one pulse per accepted request, never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_size_q  <= SZ_B;
      rsp_uns_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && acc_err;
      rsp_load_q  <= ld_en;
      if (accept) begin
        rsp_lo_q   <= bus.req_addr[1:0];
        rsp_size_q <= req_size;
        rsp_uns_q  <= bus.req_unsigned;
      end
    end
  end

  // Store and error responses carry zero data.
  assign bus.rsp_rdata = rsp_load_q ? rd_data : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q == INIT);
  assign bus.req_ready = (state_q == RUN);

endmodule

// File: doc/data_ram_be.md
DATA_RAM_BE -- requirements
Module: data_ram_be

Interface
REQ-001 Parameter ADDR_W, default 12, meaning byte-address width; depth SHALL be 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter CLEAR_ON_RESET, default 1, meaning 1 = zero-fill the array after reset, 0 = skip the fill.
REQ-003 Port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1, meaning a request is presented.
REQ-006 Port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 Port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-008 Port req_addr, input, ADDR_W, meaning byte address.
REQ-009 Port req_size, input, 2, meaning 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 Port req_unsigned, input, 1, meaning zero-extend a load when 1, sign-extend when 0.
REQ-011 Port req_wdata, input, 32, meaning store data, right-aligned.
REQ-012 Port rsp_valid, output, 1, meaning the response is valid this cycle.
REQ-013 Port rsp_rdata, output, 32, meaning the extended load result.
REQ-014 Port rsp_err, output, 1, meaning the access was misaligned or used an illegal size.
REQ-015 Port busy, output, 1, meaning the fill sweep is in progress.

Function
REQ-016 The block SHALL have two states, INIT and RUN; reset SHALL enter INIT with the sweep pointer at 0.
REQ-017 In INIT, the block SHALL write 0 to word[ptr] and increment ptr by 1 each cycle.
REQ-018 After writing word DEPTH-1, the block SHALL enter RUN on the next edge.
REQ-019 The INIT sweep SHALL take exactly DEPTH cycles.
REQ-020 With CLEAR_ON_RESET=0, INIT SHALL last one cycle and SHALL write nothing.
REQ-021 busy SHALL be 1 in INIT and 0 in RUN.
REQ-022 req_ready SHALL be 0 in INIT and 1 in RUN.
REQ-023 A request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-024 Every accepted request SHALL produce exactly one rsp_valid pulse, on the following cycle.
REQ-025 A response SHALL NOT be back-pressured; back-to-back requests SHALL give back-to-back responses.
REQ-026 An access SHALL be misaligned when size=half and addr[0]=1, or when size=word and addr[1:0]!=0.
REQ-027 An access with size=11 SHALL be treated as an error.
REQ-028 Store byte lanes SHALL be: byte 1<<addr[1:0]; half 0011 or 1100 chosen by addr[1]; word 1111.
REQ-029 Store data SHALL be replicated across lanes, so only the enabled lanes of word[addr>>2] change, at the accepting edge.
REQ-030 A load SHALL read word[addr>>2] synchronously, then shift by addr[1:0] and extend per req_size and req_unsigned.
REQ-031 For a store response, rsp_rdata SHALL be 0.
REQ-032 For an error, no array write SHALL occur, rsp_err SHALL be 1, and rsp_rdata SHALL be 0; otherwise rsp_err SHALL be 0.
REQ-033 A load accepted on the cycle after a store to the same word SHALL return the newly stored data.
REQ-034 Address bits above ADDR_W SHALL NOT exist; the word index SHALL be addr[ADDR_W-1:2], with no wrap logic beyond truncation.

Reset
REQ-035 On rst_n=0, asynchronously: state=INIT, ptr=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=1, req_ready=0.
REQ-036 Reset asserted mid-sweep SHALL restart the sweep at word 0.
REQ-037 Reset asserted in the same cycle as an accept SHALL suppress that write and that response.
REQ-038 Array contents SHALL NOT be reset directly; only the sweep clears them.

Structure
REQ-039 A shared package SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the state enum (INIT, RUN).
REQ-040 A combinational sub-module dmem_align SHALL compute the lane enables, replicated store data, misalign/error flag, and load extract/extend.
REQ-041 The top level SHALL hold the array, the FSM, the sweep pointer and the response registers.

Verification
REQ-042 Reset release, CLEAR_ON_RESET=1, ADDR_W=6 -> busy=1 for 16 cycles, then req_ready=1; a load of any word -> 0.
REQ-043 Word store 0x8000_00F0 at address 0x8, then byte load at 0x8 signed -> 0xFFFF_FFF0; byte load at 0x8 unsigned -> 0x0000_00F0; half load at 0xA signed -> 0xFFFF_8000.
REQ-044 Byte store 0xAB at address 0x5 over word 0x1122_3344 at 0x4 -> word load at 0x4 returns 0x1122_AB44.
REQ-045 Word store at 0x6 -> rsp_err=1 and the array is unchanged; half load at 0x3 -> rsp_err=1 and rsp_rdata=0.
REQ-046 Store 0xDEAD_BEEF at 0xC, then a load of 0xC on the next cycle -> rsp_rdata=0xDEAD_BEEF, with rsp_valid asserted on both consecutive cycles.
REQ-047 rst_n pulsed low at sweep cycle 5 -> the sweep restarts, busy lasts a full DEPTH cycles after release, and no response is issued.
